fx_noise_gate: RTL and testbench
================================

# fx_noise_gate

Stereo noise gate that sits directly upstream of the compressor in the effects chain. It mutes low-level hiss between phrases so the compressor's makeup gain does not amplify it. It runs on the shared 50 MHz clock with the per-sample strobe `sample_en`, applies a ramped gain with hysteresis, hold and release, and forwards a delayed strobe (`sample_en_out`) that the compressor consumes alongside `audio_out`.

## Interface
- `DATA_W`, 16, sample width, signed two's complement per channel.
- `PARAM_W`, 8, width of each user control.
- `GAIN_W`, 16, unsigned gain register width; unity gain = 2^(GAIN_W-1) = 32768.

- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `sample_en`  input  1  one-cycle strobe, one per audio sample.
- `audio_in`  input  [1:0][DATA_W]  signed stereo sample; index 0 = L, 1 = R; valid when `sample_en`=1.
- `fx_threshold`  input  PARAM_W  open threshold code.
- `fx_attack`  input  PARAM_W  attack ramp rate.
- `fx_release`  input  PARAM_W  release ramp rate.
- `fx_hold`  input  PARAM_W  hold time code.
- `audio_out`  output  [1:0][DATA_W]  gated signed stereo sample.
- `sample_en_out`  output  1  strobe marking a new `audio_out`.
- `gate_open`  output  1  status: 1 in OPEN or HOLD.

## Operation
- All state, gain and counter updates happen only on cycles with `sample_en`=1. On all other cycles, everything holds except `sample_en_out`.
- Level detector:
  - `peak = max(|L|, |R|)`.
  - `|-32768|` saturates to 32767.
- Thresholds:
  - `open_thr = fx_threshold << (DATA_W-1-PARAM_W)`, i.e. ×128.
  - `close_thr = open_thr >> 1`, giving hysteresis.
  - `fx_threshold`=0 makes `peak >= open_thr` always true, so the gate opens via attack and stays open.
- Steps:
  - `att_step = fx_attack + 1`.
  - `rel_step = fx_release + 1`.
  - Gain saturates at [0, 32768].
- Hold length: `fx_hold × 64` samples. The counter is PARAM_W+6 bits wide.
- States and transitions, evaluated per `sample_en`:
  - CLOSED, gain = 0.
    - `peak >= open_thr` → ATTACK.
  - ATTACK: gain += `att_step`.
    - When the new gain reaches 32768 → OPEN.
    - The level is ignored in this state.
  - OPEN, gain = 32768.
    - `peak < close_thr` → HOLD, and the counter is cleared.
  - HOLD, gain = 32768, counter += 1.
    - `peak >= open_thr` → OPEN.
    - Otherwise, when counter = hold length → RELEASE.
    - `fx_hold`=0 means HOLD lasts exactly one sample.
  - RELEASE: gain -= `rel_step`.
    - `peak >= open_thr` → ATTACK, continuing from the current gain with no jump.
    - When the new gain reaches 0 → CLOSED.
- Datapath, per channel:
  - `out = (audio_in × gain) >>> 15`.
  - Signed DATA_W × unsigned GAIN_W+1 operand gives a 33-bit product.
  - Result is floor-truncated.
  - No saturation is required, because gain ≤ unity.
  - The output uses the gain register value *before* this sample's update.
- Control inputs are sampled at each `sample_en`. Mid-run changes take effect on the next sample with no glitch.

## Timing
- Latency: `audio_out` and `sample_en_out`=1 appear on the first clock edge after the edge that sampled `sample_en`=1. This is exactly one cycle.
- `sample_en_out` is high for one cycle per input strobe.
- `audio_out` holds its value between strobes.
- Back-to-back `sample_en` on consecutive cycles must be supported: one output per cycle, with no drop.
- Reset values:
  - `audio_out` = 0.
  - `sample_en_out` = 0.
  - `gate_open` = 0.
  - gain = 0.
  - state = CLOSED.
  - hold counter = 0.
- Reset asserted mid-operation returns all of the above to these values on the next edge, overriding a coincident `sample_en`.
- `gate_open` is registered and updates on the same edge as the state.

## Test plan
- **Reset:** hold `reset`=1 for 10 cycles while `sample_en` toggles with input 20000.
  - Required: `audio_out`=0, `sample_en_out`=0, `gate_open`=0 throughout.
  - After release of reset: first `sample_en_out` exactly 1 cycle after the first `sample_en`.
- **Below threshold:** `fx_threshold`=64 (open at 8192), 1 kHz sine with amplitude 4096 for 200 samples.
  - Required: every `audio_out`=0, `gate_open`=0.
- **Attack ramp:** `fx_attack`=255, constant input L=R=10000.
  - Output sequence: 0, 78, 156, …
  - Output reaches 10000 on the sample after gain hits 32768 (128th update).
  - `gate_open` rises at that update.
- **Hold and release:** from OPEN, set `fx_hold`=1 and `fx_release`=255, then drop the input to 1000 (below `close_thr` 4096).
  - Required: 65 samples output 1000.
  - Then the output decays to 0 over 128 samples.
  - The state ends in CLOSED and `gate_open` falls at entry to RELEASE.
- **Retrigger:** during RELEASE at gain ≈ 16384, raise the input to 10000.
  - Required: the next output is about 5000.
  - It then ramps upward from there, with no jump to 0 or to full scale.
- **Full scale / pass-through:** `fx_threshold`=0, input L=-32768, R=32767.
  - After the attack completes: `audio_out` = {-32768, 32767} bit-exact.
  - The level detector does not overflow.

Source files
------------

// File: rtl/fx_noise_gate_if.sv
// Sample-stream and control bundle between the effects chain and fx_noise_gate.
// The gate is the slave; whoever feeds samples and controls is the master.
interface fx_noise_gate_if #(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 8
);
    logic                    sample_en;
    logic [1:0][DATA_W-1:0]  audio_in;
    logic [PARAM_W-1:0]      fx_threshold;
    logic [PARAM_W-1:0]      fx_attack;
    logic [PARAM_W-1:0]      fx_release;
    logic [PARAM_W-1:0]      fx_hold;
    logic [1:0][DATA_W-1:0]  audio_out;
    logic                    sample_en_out;
    logic                    gate_open;

    modport master (
        output sample_en, audio_in, fx_threshold, fx_attack, fx_release, fx_hold,
        input  audio_out, sample_en_out, gate_open
    );

    modport slave (
        input  sample_en, audio_in, fx_threshold, fx_attack, fx_release, fx_hold,
        output audio_out, sample_en_out, gate_open
    );
endinterface

// File: rtl/fx_noise_gate.sv
// Stereo noise gate: peak detector, hysteretic open/close with hold, and a
// ramped gain applied to both channels with one sample-strobe of latency.
module fx_noise_gate #(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 8,
    parameter int GAIN_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    fx_noise_gate_if.slave gif
);
    localparam int HOLD_W = PARAM_W + 6;
    localparam logic [GAIN_W-1:0] UNITY   = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAG_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_ATTACK,
        ST_OPEN,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic [GAIN_W-1:0]      gain_q, gain_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [1:0][DATA_W-1:0] audio_out_q, audio_out_d;
    logic                   sample_en_out_q, sample_en_out_d;
    logic                   gate_open_q, gate_open_d;

    logic [DATA_W-1:0]      mag [2];
    logic [1:0][DATA_W-1:0] gated;
    logic [DATA_W-1:0]      peak;
    logic [DATA_W-1:0]      open_thr;
    logic [DATA_W-1:0]      close_thr;
    logic [HOLD_W-1:0]      hold_len;
    logic [GAIN_W:0]        att_step;
    logic [GAIN_W:0]        rel_step;
    logic [GAIN_W:0]        gain_sum;
    logic [GAIN_W-1:0]      gain_up;
    logic [GAIN_W-1:0]      gain_dn;
    logic                   loud;
    logic                   quiet;

    // Per-channel magnitude (|-full scale| clamps to +full scale) and gain multiply
    // using the gain held before this sample's update.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [DATA_W-1:0]          raw;
            logic [DATA_W-1:0]          neg;
            logic signed [DATA_W+GAIN_W:0] prod;

            assign raw = gif.audio_in[gi];
            assign neg = '0 - raw;
            assign mag[gi] = !raw[DATA_W-1]       ? raw     :
                             (raw[DATA_W-2:0] == '0) ? MAG_MAX : neg;
            assign prod = $signed(raw) * $signed({1'b0, gain_q});
            assign gated[gi] = prod[DATA_W+GAIN_W-2 : GAIN_W-1];
        end
    endgenerate

    assign peak      = (mag[0] > mag[1]) ? mag[0] : mag[1];
    assign open_thr  = DATA_W'(gif.fx_threshold) << (DATA_W - 1 - PARAM_W);
    assign close_thr = open_thr >> 1;
    assign loud      = (peak >= open_thr);
    assign quiet     = (peak < close_thr);
    assign hold_len  = {gif.fx_hold, 6'b0};

    assign att_step = (GAIN_W+1)'(gif.fx_attack) + 1'b1;
    assign rel_step = (GAIN_W+1)'(gif.fx_release) + 1'b1;
    assign gain_sum = {1'b0, gain_q} + att_step;
    assign gain_up  = (gain_sum >= {1'b0, UNITY}) ? UNITY : gain_sum[GAIN_W-1:0];
    assign gain_dn  = ({1'b0, gain_q} <= rel_step) ? '0 : gain_q - rel_step[GAIN_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_CLOSED;
            gain_q          <= '0;
            hold_cnt_q      <= '0;
            audio_out_q     <= '0;
            sample_en_out_q <= 1'b0;
            gate_open_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            gain_q          <= gain_d;
            hold_cnt_q      <= hold_cnt_d;
            audio_out_q     <= audio_out_d;
            sample_en_out_q <= sample_en_out_d;
            gate_open_q     <= gate_open_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (gif.sample_en) begin
            case (state_q)
                ST_CLOSED: begin
                    if (loud) state_d = (gain_up == UNITY) ? ST_OPEN : ST_ATTACK;
                end
                ST_ATTACK: begin
                    if (gain_up == UNITY) state_d = ST_OPEN;
                end
                ST_OPEN: begin
                    if (quiet) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (loud)                         state_d = ST_OPEN;
                    else if (hold_cnt_q == hold_len)  state_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (loud)              state_d = (gain_up == UNITY) ? ST_OPEN : ST_ATTACK;
                    else if (gain_dn == '0) state_d = ST_CLOSED;
                end
                default: state_d = ST_CLOSED;
            endcase
        end
    end

    always_comb begin
        gain_d          = gain_q;
        hold_cnt_d      = hold_cnt_q;
        audio_out_d     = audio_out_q;
        gate_open_d     = gate_open_q;
        sample_en_out_d = gif.sample_en;
        if (gif.sample_en) begin
            audio_out_d = gated;
            gate_open_d = (state_d == ST_OPEN) || (state_d == ST_HOLD);
            case (state_q)
                ST_CLOSED:  if (loud) gain_d = gain_up;
                ST_ATTACK:  gain_d = gain_up;
                ST_OPEN: begin
                    gain_d = UNITY;
                    if (quiet) hold_cnt_d = '0;
                end
                ST_HOLD: begin
                    gain_d     = UNITY;
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                // A retrigger ramps up from wherever the release had reached.
                ST_RELEASE: gain_d = loud ? gain_up : gain_dn;
                default:    gain_d = '0;
            endcase
        end
    end

    assign gif.audio_out     = audio_out_q;
    assign gif.sample_en_out = sample_en_out_q;
    assign gif.gate_open     = gate_open_q;
endmodule

// File: tb/tb_fx_noise_gate.sv
// Scoreboard bench for fx_noise_gate: directed phases push expected outputs,
// a negedge monitor pops and compares each time sample_en_out is seen.
module tb_fx_noise_gate;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fx_noise_gate_if #(.DATA_W(16), .PARAM_W(8)) gif ();

    fx_noise_gate #(.DATA_W(16), .PARAM_W(8), .GAIN_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .gif   (gif)
    );

    typedef struct {
        int l;
        int r;
        bit g;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;
    int   gap    = 1;
    logic last_se  = 1'b0;
    logic last_rst = 1'b1;

    always @(posedge clk) begin
        last_se  <= gif.sample_en;
        last_rst <= reset;
    end

    always @(negedge clk) begin
        exp_t e;
        int   al, ar;
        al = $signed(gif.audio_out[0]);
        ar = $signed(gif.audio_out[1]);
        if (last_rst) begin
            checks++;
            if (gif.audio_out !== '0 || gif.sample_en_out !== 1'b0 || gif.gate_open !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: got L=%0d R=%0d seo=%b gate=%b, want all 0",
                         al, ar, gif.sample_en_out, gif.gate_open);
            end
        end else begin
            if (last_se || gif.sample_en_out) begin
                checks++;
                if (gif.sample_en_out !== last_se) begin
                    errors++;
                    $display("FAIL strobe_latency: got sample_en_out=%b, want %b", gif.sample_en_out, last_se);
                end
            end
            if (gif.sample_en_out === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got L=%0d R=%0d with empty scoreboard", al, ar);
                end else begin
                    e = sb.pop_front();
                    txn++;
                    if (al != e.l || ar != e.r || gif.gate_open !== e.g) begin
                        errors++;
                        $display("FAIL sample_%0d: got L=%0d R=%0d gate=%b, want L=%0d R=%0d gate=%b",
                                 txn, al, ar, gif.gate_open, e.l, e.r, e.g);
                    end else begin
                        $display("txn %0d: L=%0d R=%0d gate=%b ok", txn, al, ar, gif.gate_open);
                    end
                end
            end
        end
    end

    task automatic send(input int l, input int r, input int el, input int er, input bit eg);
        exp_t e;
        e.l = el;
        e.r = er;
        e.g = eg;
        sb.push_back(e);
        gif.audio_in[0] = 16'(l);
        gif.audio_in[1] = 16'(r);
        gif.sample_en   = 1'b1;
        @(posedge clk); #1;
        gif.sample_en   = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // Attack from closed: gain before sample k is 256*k, capped at unity.
    task automatic attack_run(input int al, input int ar, input int n);
        int u;
        for (int k = 0; k < n; k++) begin
            u = (k < 128) ? k : 128;
            send(al, ar, (al * u) >>> 7, (ar * u) >>> 7, k >= 127);
        end
    endtask

    // From OPEN with fx_hold=1: one open sample, 65 hold samples, then release.
    task automatic open_to_release(input int n_rel);
        send(1000, 1000, 1000, 1000, 1'b1);
        for (int j = 0; j <= 64; j++) send(1000, 1000, 1000, 1000, j < 64);
        for (int m = 0; m < n_rel; m++)
            send(1000, 1000, (1000 * (128 - m)) >>> 7, (1000 * (128 - m)) >>> 7, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        gif.sample_en    = 1'b0;
        gif.audio_in[0]  = 16'd20000;
        gif.audio_in[1]  = 16'd20000;
        gif.fx_threshold = 8'd64;
        gif.fx_attack    = 8'd255;
        gif.fx_release   = 8'd255;
        gif.fx_hold      = 8'd1;

        // Reset held while strobes toggle with a loud input.
        repeat (10) begin
            @(posedge clk); #1;
            gif.sample_en = ~gif.sample_en;
        end
        reset         = 1'b0;
        gif.sample_en = 1'b0;
        @(posedge clk); #1;

        // 1 kHz sine at 48 kHz, amplitude 4096: under the 8192 open threshold.
        for (int k = 0; k < 200; k++) begin
            v = $rtoi(4096.0 * $sin(2.0 * 3.14159265358979 * k / 48.0));
            send(v, -v, 0, 0, 1'b0);
        end

        attack_run(10000, 10000, 130);

        open_to_release(128);
        send(1000, 1000, 0, 0, 1'b0);
        send(1000, 1000, 0, 0, 1'b0);

        // Retrigger at gain 16384 during release.
        attack_run(10000, 10000, 128);
        open_to_release(64);
        for (int n = 0; n <= 65; n++)
            send(10000, 10000, (10000 * ((64 + n) < 128 ? 64 + n : 128)) >>> 7,
                 (10000 * ((64 + n) < 128 ? 64 + n : 128)) >>> 7, n >= 63);

        // Reset mid-operation wins over a coincident strobe.
        reset           = 1'b1;
        gif.sample_en   = 1'b1;
        gif.audio_in[0] = 16'd10000;
        gif.audio_in[1] = 16'd10000;
        @(posedge clk); #1;
        reset         = 1'b0;
        gif.sample_en = 1'b0;
        @(posedge clk); #1;

        // Full-scale pass-through with threshold 0, back-to-back strobes.
        gif.fx_threshold = 8'd0;
        gap = 0;
        attack_run(-32768, 32767, 130);

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outputs still pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
